// File: rtl/seq_divider32_pkg.sv
// Shared definitions for the sequential 32-bit divider: widths, iteration count and FSM states.
package seq_divider32_pkg;

  localparam int unsigned DIV_WIDTH = 32;
  localparam int unsigned DIV_ITERS = 32;
  localparam logic [31:0] INT_MIN   = 32'h8000_0000;

  typedef enum logic [2:0] {
    DIV_IDLE = 3'd0,
    DIV_PREP = 3'd1,
    DIV_ITER = 3'd2,
    DIV_FIX  = 3'd3,
    DIV_DONE = 3'd4
  } div_state_e;

endpackage

// File: rtl/seq_divider32_if.sv
// Request/result bundle between the MDU issue logic (master) and the divider (slave).
interface seq_divider32_if;

  logic                                  start;
  logic                                  is_signed;
  logic [seq_divider32_pkg::DIV_WIDTH-1:0] dividend;
  logic [seq_divider32_pkg::DIV_WIDTH-1:0] divisor;
  logic                                  busy;
  logic                                  done;
  logic [seq_divider32_pkg::DIV_WIDTH-1:0] quotient;
  logic [seq_divider32_pkg::DIV_WIDTH-1:0] remainder;
  logic                                  dz;
  logic                                  ovf;

  modport master (
    output start, is_signed, dividend, divisor,
    input  busy, done, quotient, remainder, dz, ovf
  );

  modport slave (
    input  start, is_signed, dividend, divisor,
    output busy, done, quotient, remainder, dz, ovf
  );

endinterface

// File: rtl/cla_addsub32.sv
// 32-bit carry-lookahead adder/subtractor (op=1: a-b, cf=1 means no borrow), 4-bit lookahead groups.
module cla_addsub32
  import seq_divider32_pkg::*;
(
  input  logic [31:0] i_a,
  input  logic [31:0] i_b,
  input  logic        i_op,
  output logic [31:0] o_sum,
  output logic        o_cf
);

  logic [31:0] w_bx;
  logic [31:0] w_g;
  logic [31:0] w_p;
  logic [32:0] w_c;
  logic        w_gg;
  logic        w_gp;

  always_comb begin
    w_bx = i_b ^ {32{i_op}};
    w_g  = i_a & w_bx;
    w_p  = i_a ^ w_bx;
    w_c  = '0;
    w_gg = 1'b0;
    w_gp = 1'b1;
    w_c[0] = i_op;
    for (int unsigned k = 0; k < 8; k++) begin
      w_gg = 1'b0;
      w_gp = 1'b1;
      for (int unsigned j = 0; j < 4; j++) begin
        w_gg = w_g[4*k+j] | (w_p[4*k+j] & w_gg);
        w_gp = w_gp & w_p[4*k+j];
      end
      for (int unsigned j = 0; j < 3; j++) begin
        w_c[4*k+j+1] = w_g[4*k+j] | (w_p[4*k+j] & w_c[4*k+j]);
      end
      // group carry-out comes straight from group generate/propagate
      w_c[4*k+4] = w_gg | (w_gp & w_c[4*k]);
    end
  end

  assign o_sum = w_p ^ w_c[31:0];
  assign o_cf  = w_c[32];

endmodule

// File: rtl/div_abs32.sv
// Conditional two's-complement negate; wraps, so INT_MIN maps to itself.
module div_abs32
  import seq_divider32_pkg::*;
(
  input  logic        i_en,
  input  logic [31:0] i_data,
  output logic [31:0] o_data
);

  assign o_data = i_en ? (~i_data + 32'd1) : i_data;

endmodule

// File: rtl/seq_divider32.sv
// Multi-cycle restoring divider (signed/unsigned); one CLA trial subtraction per iteration.
module seq_divider32
  import seq_divider32_pkg::*;
#(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned CNT_W = 6
) (
  input  logic            clk,
  input  logic            rst,
  seq_divider32_if.slave  bus
);

  div_state_e       r_state, w_state_nxt;
  logic [CNT_W-1:0] r_cnt;
  logic [WIDTH-1:0] r_dvd, r_dvs, r_dvs_abs, r_q, r_rem_p, r_quot, r_rem;
  logic             r_signed, r_qneg, r_rneg;
  logic             r_busy, r_done, r_dz, r_ovf;

  logic             w_accept, w_dz_op, w_ovf_op;
  logic             w_dvd_neg, w_dvs_neg, w_cf, w_ge;
  logic [WIDTH-1:0] w_dvd_abs, w_dvs_abs, w_trial, w_quot_fix, w_rem_fix;
  logic [WIDTH:0]   w_rs;

  assign w_dz_op   = (r_dvs == '0);
  assign w_ovf_op  = r_signed & (r_dvd == INT_MIN) & (r_dvs == '1);
  assign w_dvd_neg = r_signed & r_dvd[WIDTH-1];
  assign w_dvs_neg = r_signed & r_dvs[WIDTH-1];

  // Stored remainder is always below the divisor, so only the shifted value needs bit 32.
  assign w_rs = {r_rem_p, r_q[WIDTH-1]};
  assign w_ge = w_rs[WIDTH] | w_cf;

  div_abs32 u_abs_dvd (.i_en(w_dvd_neg), .i_data(r_dvd),   .o_data(w_dvd_abs));
  div_abs32 u_abs_dvs (.i_en(w_dvs_neg), .i_data(r_dvs),   .o_data(w_dvs_abs));
  div_abs32 u_abs_q   (.i_en(r_qneg),    .i_data(r_q),     .o_data(w_quot_fix));
  div_abs32 u_abs_r   (.i_en(r_rneg),    .i_data(r_rem_p), .o_data(w_rem_fix));

  cla_addsub32 u_cla (
    .i_a   (w_rs[WIDTH-1:0]),
    .i_b   (r_dvs_abs),
    .i_op  (1'b1),
    .o_sum (w_trial),
    .o_cf  (w_cf)
  );

  always_comb begin
    w_state_nxt = r_state;
    w_accept    = 1'b0;
    unique case (r_state)
      DIV_IDLE: if (bus.start) begin
        w_accept    = 1'b1;
        w_state_nxt = DIV_PREP;
      end
      // zero divisor skips ITER but still passes through FIX so done lands two cycles after start
      DIV_PREP: w_state_nxt = w_dz_op ? DIV_FIX : DIV_ITER;
      DIV_ITER: if (r_cnt == CNT_W'(DIV_ITERS - 1)) w_state_nxt = DIV_FIX;
      DIV_FIX:  w_state_nxt = DIV_DONE;
      DIV_DONE: begin
        w_accept    = bus.start;
        w_state_nxt = bus.start ? DIV_PREP : DIV_IDLE;
      end
      default:  w_state_nxt = DIV_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= DIV_IDLE;
      r_cnt     <= '0;
      r_dvd     <= '0;
      r_dvs     <= '0;
      r_dvs_abs <= '0;
      r_q       <= '0;
      r_rem_p   <= '0;
      r_quot    <= '0;
      r_rem     <= '0;
      r_signed  <= 1'b0;
      r_qneg    <= 1'b0;
      r_rneg    <= 1'b0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
      r_dz      <= 1'b0;
      r_ovf     <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_done  <= 1'b0;
      if (w_accept) begin
        r_dvd    <= bus.dividend;
        r_dvs    <= bus.divisor;
        r_signed <= bus.is_signed;
        r_busy   <= 1'b1;
        r_dz     <= 1'b0;
        r_ovf    <= 1'b0;
      end
      case (r_state)
        DIV_PREP: begin
          r_q       <= w_dvd_abs;
          r_dvs_abs <= w_dvs_abs;
          r_rem_p   <= '0;
          r_qneg    <= w_dvd_neg ^ w_dvs_neg;
          r_rneg    <= w_dvd_neg;
          r_cnt     <= '0;
        end
        DIV_ITER: begin
          r_cnt   <= r_cnt + CNT_W'(1);
          r_rem_p <= w_ge ? w_trial : w_rs[WIDTH-1:0];
          r_q     <= {r_q[WIDTH-2:0], w_ge};
        end
        DIV_FIX: begin
          r_busy <= 1'b0;
          r_done <= 1'b1;
          if (w_dz_op) begin
            r_quot <= '1;
            r_rem  <= r_dvd;
            r_dz   <= 1'b1;
          end else begin
            r_quot <= w_quot_fix;
            r_rem  <= w_rem_fix;
            r_ovf  <= w_ovf_op;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.busy      = r_busy;
  assign bus.done      = r_done;
  assign bus.quotient  = r_quot;
  assign bus.remainder = r_rem;
  assign bus.dz        = r_dz;
  assign bus.ovf       = r_ovf;

endmodule

// File: tb/tb_seq_divider32.sv
// Self-checking bench for seq_divider32: directed cases plus randomized ops against an arithmetic model.
module tb_seq_divider32;
  import seq_divider32_pkg::*;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  seq_divider32_if bus();

  seq_divider32 #(.WIDTH(32), .CNT_W(6)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int total = 0;
  int bad   = 0;

  // Plain-arithmetic reference: truncating divide, remainder follows the dividend.
  function automatic void ref_div(input logic sgn, input logic [31:0] a, input logic [31:0] b,
                                  output logic [31:0] q, output logic [31:0] r,
                                  output logic dz, output logic ovf);
    longint sa, sb;
    dz = 1'b0; ovf = 1'b0;
    if (b == 32'd0) begin
      q = 32'hFFFF_FFFF; r = a; dz = 1'b1;
    end else if (sgn) begin
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      q = 32'(sa / sb);
      r = 32'(sa % sb);
      ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
    end else begin
      q = a / b;
      r = a % b;
    end
  endfunction

  // Issue one op (start high for one sampled edge) and wait for done; lat counts cycles after the start edge.
  task automatic run_div(input logic sgn, input logic [31:0] a, input logic [31:0] b,
                         output int lat, output int busy_cyc, output logic busy_at_done,
                         output logic to);
    bus.is_signed = sgn;
    bus.dividend  = a;
    bus.divisor   = b;
    bus.start     = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    lat = 0; busy_cyc = 0; to = 1'b0;
    while (bus.done !== 1'b1) begin
      if (bus.busy === 1'b1) busy_cyc++;
      if (lat >= 100) begin to = 1'b1; break; end
      @(posedge clk); #1;
      lat++;
    end
    busy_at_done = bus.busy;
  endtask

  task automatic test_reset();
    bus.start = 1'b0; bus.is_signed = 1'b0; bus.dividend = '0; bus.divisor = '0;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    total++; if ({bus.busy, bus.done, bus.dz, bus.ovf} !== 4'b0000) begin
      bad++; $display("FAIL reset_flags got=%b exp=0000", {bus.busy, bus.done, bus.dz, bus.ovf});
    end
    total++; if ({bus.quotient, bus.remainder} !== 64'd0) begin
      bad++; $display("FAIL reset_qr got=%h_%h exp=0_0", bus.quotient, bus.remainder);
    end
    rst = 1'b0;
  endtask

  task automatic test_unsigned();
    int lat, bc; logic bd, to;
    run_div(1'b0, 32'd100, 32'd7, lat, bc, bd, to);
    total++; if (to !== 1'b0) begin bad++; $display("FAIL u100_7_timeout got=%b exp=0", to); end
    total++; if (bus.quotient !== 32'd14) begin bad++; $display("FAIL u100_7_q got=%h exp=%h", bus.quotient, 32'd14); end
    total++; if (bus.remainder !== 32'd2) begin bad++; $display("FAIL u100_7_r got=%h exp=%h", bus.remainder, 32'd2); end
    total++; if ({bus.dz, bus.ovf} !== 2'b00) begin bad++; $display("FAIL u100_7_flags got=%b exp=00", {bus.dz, bus.ovf}); end
    total++; if (lat !== 34) begin bad++; $display("FAIL u100_7_latency got=%0d exp=34", lat); end
    total++; if (bc !== 34) begin bad++; $display("FAIL u100_7_busy_cycles got=%0d exp=34", bc); end
    total++; if (bd !== 1'b0) begin bad++; $display("FAIL u100_7_busy_at_done got=%b exp=0", bd); end
    @(posedge clk); #1;
    total++; if (bus.done !== 1'b0) begin bad++; $display("FAIL done_pulse_width got=%b exp=0", bus.done); end
    total++; if (bus.quotient !== 32'd14) begin bad++; $display("FAIL q_held got=%h exp=%h", bus.quotient, 32'd14); end
  endtask

  task automatic test_signed();
    int lat, bc; logic bd, to;
    run_div(1'b1, 32'hFFFF_FFF9, 32'd2, lat, bc, bd, to);
    total++; if ({bus.quotient, bus.remainder} !== {32'hFFFF_FFFD, 32'hFFFF_FFFF}) begin
      bad++; $display("FAIL s_m7_2 got=%h_%h exp=fffffffd_ffffffff", bus.quotient, bus.remainder);
    end
    run_div(1'b1, 32'd7, 32'hFFFF_FFFE, lat, bc, bd, to);
    total++; if ({bus.quotient, bus.remainder} !== {32'hFFFF_FFFD, 32'd1}) begin
      bad++; $display("FAIL s_7_m2 got=%h_%h exp=fffffffd_00000001", bus.quotient, bus.remainder);
    end
    total++; if (lat !== 34) begin bad++; $display("FAIL s_7_m2_latency got=%0d exp=34", lat); end
  endtask

  task automatic test_div_zero();
    int lat, bc; logic bd, to;
    run_div(1'b1, 32'h1234_5678, 32'd0, lat, bc, bd, to);
    total++; if ({bus.quotient, bus.remainder} !== {32'hFFFF_FFFF, 32'h1234_5678}) begin
      bad++; $display("FAIL dz_qr got=%h_%h exp=ffffffff_12345678", bus.quotient, bus.remainder);
    end
    total++; if ({bus.dz, bus.ovf} !== 2'b10) begin bad++; $display("FAIL dz_flags got=%b exp=10", {bus.dz, bus.ovf}); end
    total++; if (lat !== 2) begin bad++; $display("FAIL dz_latency got=%0d exp=2", lat); end
    total++; if (bc !== 2) begin bad++; $display("FAIL dz_busy_cycles got=%0d exp=2", bc); end
  endtask

  task automatic test_overflow();
    int lat, bc; logic bd, to;
    run_div(1'b1, 32'h8000_0000, 32'hFFFF_FFFF, lat, bc, bd, to);
    total++; if ({bus.quotient, bus.remainder} !== {32'h8000_0000, 32'd0}) begin
      bad++; $display("FAIL ovf_qr got=%h_%h exp=80000000_00000000", bus.quotient, bus.remainder);
    end
    total++; if ({bus.dz, bus.ovf} !== 2'b01) begin bad++; $display("FAIL ovf_flags got=%b exp=01", {bus.dz, bus.ovf}); end
    total++; if (lat !== 34) begin bad++; $display("FAIL ovf_latency got=%0d exp=34", lat); end
    run_div(1'b0, 32'hFFFF_FFFF, 32'd1, lat, bc, bd, to);
    total++; if ({bus.quotient, bus.remainder} !== {32'hFFFF_FFFF, 32'd0}) begin
      bad++; $display("FAIL u_max_1 got=%h_%h exp=ffffffff_00000000", bus.quotient, bus.remainder);
    end
    total++; if ({bus.dz, bus.ovf} !== 2'b00) begin bad++; $display("FAIL ovf_cleared got=%b exp=00", {bus.dz, bus.ovf}); end
  endtask

  task automatic test_busy_start_and_reset();
    int n, bc, lat; logic bd, to;
    bus.is_signed = 1'b0; bus.dividend = 32'd1000; bus.divisor = 32'd7; bus.start = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    bus.is_signed = 1'b1; bus.dividend = 32'd99; bus.divisor = 32'd3; bus.start = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    n = 6;
    while (bus.done !== 1'b1 && n < 100) begin @(posedge clk); #1; n++; end
    total++; if (n !== 34) begin bad++; $display("FAIL ignored_start_latency got=%0d exp=34", n); end
    total++; if ({bus.quotient, bus.remainder} !== {32'd142, 32'd6}) begin
      bad++; $display("FAIL ignored_start_qr got=%h_%h exp=0000008e_00000006", bus.quotient, bus.remainder);
    end
    bc = 0;
    repeat (4) begin @(posedge clk); #1; if (bus.busy === 1'b1 || bus.done === 1'b1) bc++; end
    total++; if (bc !== 0) begin bad++; $display("FAIL no_queued_op got=%0d exp=0", bc); end

    bus.is_signed = 1'b0; bus.dividend = 32'd12345; bus.divisor = 32'd67; bus.start = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    total++; if ({bus.busy, bus.done, bus.dz, bus.ovf} !== 4'b0000) begin
      bad++; $display("FAIL midreset_flags got=%b exp=0000", {bus.busy, bus.done, bus.dz, bus.ovf});
    end
    total++; if ({bus.quotient, bus.remainder} !== 64'd0) begin
      bad++; $display("FAIL midreset_qr got=%h_%h exp=0_0", bus.quotient, bus.remainder);
    end
    bc = 0;
    repeat (40) begin @(posedge clk); #1; if (bus.done === 1'b1 || bus.busy === 1'b1) bc++; end
    total++; if (bc !== 0) begin bad++; $display("FAIL midreset_no_done got=%0d exp=0", bc); end

    run_div(1'b0, 32'd50, 32'd5, lat, bc, bd, to);
    total++; if ({bus.quotient, bus.remainder} !== {32'd10, 32'd0}) begin
      bad++; $display("FAIL after_reset_50_5 got=%h_%h exp=0000000a_00000000", bus.quotient, bus.remainder);
    end
    total++; if (lat !== 34) begin bad++; $display("FAIL after_reset_latency got=%0d exp=34", lat); end
  endtask

  task automatic test_back_to_back();
    int lat, bc; logic bd, to;
    run_div(1'b0, 32'd77, 32'd0, lat, bc, bd, to);
    total++; if (bus.dz !== 1'b1) begin bad++; $display("FAIL b2b_first_dz got=%b exp=1", bus.dz); end
    // start is raised while still in the done cycle
    run_div(1'b1, 32'hFFFF_FF9C, 32'd9, lat, bc, bd, to);
    total++; if (lat !== 34) begin bad++; $display("FAIL b2b_latency got=%0d exp=34", lat); end
    total++; if (bc !== 34) begin bad++; $display("FAIL b2b_busy_cycles got=%0d exp=34", bc); end
    total++; if ({bus.quotient, bus.remainder} !== {32'hFFFF_FFF5, 32'hFFFF_FFFF}) begin
      bad++; $display("FAIL b2b_qr got=%h_%h exp=fffffff5_ffffffff", bus.quotient, bus.remainder);
    end
    total++; if ({bus.dz, bus.ovf} !== 2'b00) begin bad++; $display("FAIL b2b_dz_cleared got=%b exp=00", {bus.dz, bus.ovf}); end
  endtask

  function automatic logic [31:0] pick_operand();
    logic [31:0] v;
    case ($urandom_range(0, 7))
      0: v = 32'd0;
      1: v = 32'd1;
      2: v = 32'hFFFF_FFFF;
      3: v = 32'h8000_0000;
      4: v = 32'h7FFF_FFFF;
      5: v = 32'($urandom_range(0, 20));
      6: begin v = 32'($urandom_range(1, 20)); v = -v; end
      default: v = $urandom();
    endcase
    return v;
  endfunction

  task automatic test_random();
    int lat, bc; logic bd, to;
    logic sgn, edz, eovf;
    logic [31:0] a, b, eq, er;
    for (int i = 0; i < 1500; i++) begin
      sgn = 1'($urandom_range(0, 1));
      a = pick_operand();
      b = pick_operand();
      ref_div(sgn, a, b, eq, er, edz, eovf);
      run_div(sgn, a, b, lat, bc, bd, to);
      total++; if ({bus.quotient, bus.remainder} !== {eq, er}) begin
        bad++; $display("FAIL rand_qr s=%b a=%h b=%h got=%h_%h exp=%h_%h", sgn, a, b, bus.quotient, bus.remainder, eq, er);
      end
      total++; if ({bus.dz, bus.ovf} !== {edz, eovf}) begin
        bad++; $display("FAIL rand_flags s=%b a=%h b=%h got=%b exp=%b", sgn, a, b, {bus.dz, bus.ovf}, {edz, eovf});
      end
      total++; if (lat !== ((b == 32'd0) ? 2 : 34)) begin
        bad++; $display("FAIL rand_latency a=%h b=%h got=%0d exp=%0d", a, b, lat, (b == 32'd0) ? 2 : 34);
      end
    end
  endtask

  initial begin
    test_reset();
    test_unsigned();
    test_signed();
    test_div_zero();
    test_overflow();
    test_busy_start_and_reset();
    test_back_to_back();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #5ms;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1);
  end

endmodule
